// File: rtl/alu_exec_unit.sv
// Registered execute stage: single-cycle ALU plus an iterative multiply/divide
// engine with private HI/LO. Issue stalls only for instructions that touch the engine.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             illegal,
  output logic             md_busy,
  output logic             md_done
);

  localparam int SH = $clog2(WIDTH);

  typedef enum logic [4:0] {
    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
    F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA, F_LUI,
    F_MFHI, F_MFLO, F_MTHI, F_MTLO,
    F_MULT, F_MULTU, F_DIV, F_DIVU, F_ILL
  } fn_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} md_state_e;

  fn_e              fn;
  logic             var_sh;
  logic [SH-1:0]    sh_amt;
  logic             md_class;
  logic             md_start;
  logic             produces;
  logic             accept;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  md_state_e          state;
  md_state_e          state_nxt;
  logic [SH-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               neg_q;
  logic               neg_r;
  logic               md_div;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    fn     = F_ILL;
    var_sh = 1'b0;
    case (alu_op)
      3'b000: fn = F_ADDU;  // address arithmetic never flags overflow
      3'b001: fn = F_SUBU;
      3'b100: fn = F_AND;
      3'b101: fn = F_OR;
      3'b010, 3'b011: begin
        case (func)
          6'b100000: fn = F_ADD;
          6'b100001: fn = F_ADDU;
          6'b100010: fn = F_SUB;
          6'b100011: fn = F_SUBU;
          6'b100100: fn = F_AND;
          6'b100101: fn = F_OR;
          6'b100110: fn = F_XOR;
          6'b100111: fn = F_NOR;
          6'b101010: fn = F_SLT;
          6'b101011: fn = F_SLTU;
          6'b000000: fn = F_SLL;
          6'b000010: fn = F_SRL;
          6'b000011: fn = F_SRA;
          6'b000100: begin fn = F_SLL; var_sh = 1'b1; end
          6'b000110: begin fn = F_SRL; var_sh = 1'b1; end
          6'b000111: begin fn = F_SRA; var_sh = 1'b1; end
          6'b011000: fn = F_MULT;
          6'b011001: fn = F_MULTU;
          6'b011010: fn = F_DIV;
          6'b011011: fn = F_DIVU;
          6'b010000: fn = F_MFHI;
          6'b010010: fn = F_MFLO;
          6'b010001: fn = F_MTHI;
          6'b010011: fn = F_MTLO;
          default:   fn = F_ILL;
        endcase
      end
      default: begin
        case (op)
          6'b001000: fn = F_ADD;
          6'b001001: fn = F_ADDU;
          6'b001100: fn = F_AND;
          6'b001101: fn = F_OR;
          6'b001110: fn = F_XOR;
          6'b001111: fn = F_LUI;
          6'b001010: fn = F_SLT;
          6'b001011: fn = F_SLTU;
          default:   fn = F_ILL;
        endcase
      end
    endcase
  end

  assign md_class = fn inside {F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO, F_MTHI, F_MTLO};
  assign produces = !(fn inside {F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO});
  assign md_busy  = (state != S_IDLE);
  assign in_ready = !(md_busy && md_class);
  assign accept   = in_valid && in_ready && !flush;
  assign md_start = accept && (fn inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
  assign sh_amt   = var_sh ? a[SH-1:0] : SH'(shamt);
  assign sum      = a + b;
  assign dif      = a - b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (fn)
      F_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      F_ADDU: alu_res = sum;
      F_SUB: begin
        alu_res = dif;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      F_SUBU: alu_res = dif;
      F_AND:  alu_res = a & b;
      F_OR:   alu_res = a | b;
      F_XOR:  alu_res = a ^ b;
      F_NOR:  alu_res = ~(a | b);
      F_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      F_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      F_SLL:  alu_res = b << sh_amt;
      F_SRL:  alu_res = b >> sh_amt;
      F_SRA:  alu_res = $signed(b) >>> sh_amt;
      F_LUI:  alu_res = b << (WIDTH / 2);
      F_MFHI: alu_res = hi;
      F_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its inputs as they stood before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= accept && produces;
      if (accept && produces) begin
        result  <= alu_res;
        ovf     <= alu_ovf;
        illegal <= (fn == F_ILL);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (md_start) state_nxt = (fn inside {F_MULT, F_MULTU}) ? S_MUL : S_DIV;
      S_MUL, S_DIV: if (cnt == SH'(WIDTH - 1)) state_nxt = S_FIX;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign signed_op = (fn == F_MULT) || (fn == F_DIV);
  assign a_neg     = signed_op && a[WIDTH-1];
  assign b_neg     = signed_op && b[WIDTH-1];

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next  = {mul_sum, acc[WIDTH-1:1]};
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_q ? -acc : acc;
  assign quo      = acc[WIDTH-1:0];
  assign rem      = acc[2*WIDTH-1:WIDTH];
  assign fix_lo   = !md_div ? prod_fix[WIDTH-1:0] :
                    (opnd == '0) ? {WIDTH{1'b1}} : (neg_q ? -quo : quo);
  assign fix_hi   = !md_div ? prod_fix[2*WIDTH-1:WIDTH] : (neg_r ? -rem : rem);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      md_div  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      md_done <= 1'b0;
    end else begin
      md_done <= (state == S_FIX) && !flush;
      case (state)
        S_IDLE: begin
          if (md_start) begin
            cnt    <= '0;
            acc    <= {{WIDTH{1'b0}}, a_neg ? -a : a};
            opnd   <= b_neg ? -b : b;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            md_div <= (fn == F_DIV) || (fn == F_DIVU);
          end
          if (accept && fn == F_MTHI) hi <= a;
          if (accept && fn == F_MTLO) lo <= a;
        end
        S_MUL: begin
          acc <= mul_next;
          cnt <= cnt + 1'b1;
        end
        S_DIV: begin
          acc <= div_next;
          cnt <= cnt + 1'b1;
        end
        default: begin
          if (!flush) begin
            hi <= fix_hi;
            lo <= fix_lo;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed steps plus randomized ALU and
// multiply/divide traffic compared against an arithmetic reference model.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid;
  logic          in_ready;
  logic [2:0]    alu_op;
  logic [5:0]    op, func;
  logic [W-1:0]  a, b;
  logic [4:0]    shamt;
  logic          out_valid;
  logic [W-1:0]  result;
  logic          ovf, illegal, md_busy, md_done;

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_hi = '0;
  logic [31:0] ref_lo = '0;

  typedef struct {
    logic        vld;
    logic [31:0] res;
    logic        ovf;
    logic        ill;
  } exp_t;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .op(op), .func(func), .a(a), .b(b), .shamt(shamt),
    .out_valid(out_valid), .result(result), .ovf(ovf), .illegal(illegal),
    .md_busy(md_busy), .md_done(md_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] aop, input logic [5:0] o, input logic [5:0] f,
                       input logic [31:0] x, input logic [31:0] y, input logic [4:0] sa);
    alu_op = aop; op = o; func = f; a = x; b = y; shamt = sa;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic bit sovf(input longint v);
    return (v > 64'sd2147483647) || (v < -64'sd2147483648);
  endfunction

  function automatic exp_t model(input logic [2:0] aop, input logic [5:0] o, input logic [5:0] f,
                                 input logic [31:0] x, input logic [31:0] y, input logic [4:0] sa);
    exp_t e;
    longint sx, sy;
    logic signed [31:0] ys;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ys = y;
    e.vld = 1'b1; e.res = '0; e.ovf = 1'b0; e.ill = 1'b0;
    if (!aop[1]) begin
      case (aop)
        3'b000:  e.res = x + y;
        3'b001:  e.res = x - y;
        3'b100:  e.res = x & y;
        default: e.res = x | y;
      endcase
    end else if (!aop[2]) begin
      case (f)
        6'h20: begin e.res = x + y; e.ovf = sovf(sx + sy); end
        6'h21: e.res = x + y;
        6'h22: begin e.res = x - y; e.ovf = sovf(sx - sy); end
        6'h23: e.res = x - y;
        6'h24: e.res = x & y;
        6'h25: e.res = x | y;
        6'h26: e.res = x ^ y;
        6'h27: e.res = ~(x | y);
        6'h2A: e.res = (sx < sy) ? 32'd1 : 32'd0;
        6'h2B: e.res = (x < y) ? 32'd1 : 32'd0;
        6'h00: e.res = y << sa;
        6'h02: e.res = y >> sa;
        6'h03: e.res = ys >>> sa;
        6'h04: e.res = y << x[4:0];
        6'h06: e.res = y >> x[4:0];
        6'h07: e.res = ys >>> x[4:0];
        6'h10: e.res = ref_hi;
        6'h12: e.res = ref_lo;
        6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: e.vld = 1'b0;
        default: e.ill = 1'b1;
      endcase
    end else begin
      case (o)
        6'h08: begin e.res = x + y; e.ovf = sovf(sx + sy); end
        6'h09: e.res = x + y;
        6'h0C: e.res = x & y;
        6'h0D: e.res = x | y;
        6'h0E: e.res = x ^ y;
        6'h0F: e.res = y << 16;
        6'h0A: e.res = (sx < sy) ? 32'd1 : 32'd0;
        6'h0B: e.res = (x < y) ? 32'd1 : 32'd0;
        default: e.ill = 1'b1;
      endcase
    end
    return e;
  endfunction

  task automatic md_model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (f)
      6'h18: begin p = sx * sy; ref_hi = p[63:32]; ref_lo = p[31:0]; end
      6'h19: begin p = {32'd0, x} * {32'd0, y}; ref_hi = p[63:32]; ref_lo = p[31:0]; end
      6'h1A: begin
        if (y == 0) begin ref_lo = '1; ref_hi = x; end
        else begin q = sx / sy; r = sx % sy; ref_lo = q[31:0]; ref_hi = r[31:0]; end
      end
      default: begin
        if (y == 0) begin ref_lo = '1; ref_hi = x; end
        else begin ref_lo = x / y; ref_hi = x % y; end
      end
    endcase
  endtask

  task automatic read_hilo(input string tag);
    issue(3'b010, 6'h00, 6'h10, 32'h0, 32'h0, 5'd0);
    check({tag, "_mfhi"}, {out_valid, result}, {1'b1, ref_hi});
    issue(3'b010, 6'h00, 6'h12, 32'h0, 32'h0, 5'd0);
    check({tag, "_mflo"}, {out_valid, result}, {1'b1, ref_lo});
  endtask

  task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    int busy_n;
    bit done_early;
    alu_op = 3'b010; func = f; a = x; b = y; in_valid = 1'b1;
    #1;
    check({tag, "_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    busy_n = 0;
    done_early = 1'b0;
    while (md_busy === 1'b1 && busy_n < 100) begin
      if (md_done !== 1'b0) done_early = 1'b1;
      busy_n++;
      tick();
    end
    check({tag, "_busy_cycles"}, busy_n, W + 1);
    check({tag, "_done_pulse"}, {done_early, md_done}, 2'b01);
    md_model(f, x, y);
    read_hilo(tag);
  endtask

  exp_t e;
  logic [31:0] r1, r2;
  bit done_seen;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    alu_op = '0; op = '0; func = '0; a = '0; b = '0; shamt = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset_outs", {out_valid, result, ovf, illegal, md_busy, md_done}, '0);
    check("reset_ready", in_ready, 1'b1);
    read_hilo("reset");

    issue(3'b010, 6'h00, 6'h20, 32'h7FFFFFFF, 32'h1, 5'd0);
    check("add_ovf", {out_valid, result, ovf, illegal}, {1'b1, 32'h80000000, 1'b1, 1'b0});
    issue(3'b010, 6'h00, 6'h21, 32'h7FFFFFFF, 32'h1, 5'd0);
    check("addu", {out_valid, result, ovf}, {1'b1, 32'h80000000, 1'b0});
    issue(3'b010, 6'h00, 6'h03, 32'h0, 32'h80000000, 5'd4);
    check("sra", result, 32'hF8000000);
    issue(3'b010, 6'h00, 6'h07, 32'h24, 32'hF0, 5'd0);
    check("srav", result, 32'h0F);
    issue(3'b110, 6'h0F, 6'h00, 32'h0, 32'h1234, 5'd0);
    check("lui", result, 32'h12340000);
    issue(3'b110, 6'h0B, 6'h00, 32'h1, 32'hFFFFFFFF, 5'd0);
    check("sltiu", result, 32'd1);
    issue(3'b110, 6'h0A, 6'h00, 32'h1, 32'hFFFFFFFF, 5'd0);
    check("slti", result, 32'd0);
    issue(3'b010, 6'h00, 6'h3F, 32'h55, 32'hAA, 5'd0);
    check("illegal_r", {out_valid, result, illegal}, {1'b1, 32'h0, 1'b1});
    issue(3'b111, 6'h3F, 6'h00, 32'h55, 32'hAA, 5'd0);
    check("illegal_i", {out_valid, result, illegal}, {1'b1, 32'h0, 1'b1});

    // Back-to-back randomized single-cycle traffic.
    in_valid = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [31:0] corner [4];
      corner[0] = 32'h7FFFFFFF; corner[1] = 32'h80000000; corner[2] = 32'hFFFFFFFF; corner[3] = 32'h0;
      alu_op = 3'($urandom_range(0, 7));
      op     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(8, 15));
      func   = 6'($urandom);
      if (func inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B}) func = 6'h26;
      a      = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      b      = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      shamt  = 5'($urandom);
      e = model(alu_op, op, func, a, b, shamt);
      tick();
      check($sformatf("rand%0d_vld_res_ill", i), {out_valid, result, illegal}, {e.vld, e.res, e.ill});
      if (alu_op[1]) check($sformatf("rand%0d_ovf", i), ovf, e.ovf);
    end
    in_valid = 1'b0;

    run_md("mult", 6'h18, 32'hFFFFFFFF, 32'h2);
    run_md("multu", 6'h19, 32'hFFFFFFFF, 32'h2);
    run_md("div_neg", 6'h1A, 32'hFFFFFFF9, 32'h2);
    run_md("divu", 6'h1B, 32'd100, 32'd7);
    run_md("divu_zero", 6'h1B, 32'd5, 32'd0);
    run_md("div_zero_neg", 6'h1A, 32'hFFFFFF00, 32'd0);
    for (int i = 0; i < 6; i++) begin
      logic [5:0] f;
      logic [31:0] y;
      f = 6'($urandom_range(24, 27));
      y = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_md($sformatf("md_rand%0d", i), f, $urandom, y);
    end

    // Independent ALU ops flow under a running divide; mflo waits for it.
    r1 = $urandom; r2 = $urandom;
    alu_op = 3'b010; func = 6'h1A; a = 32'd1000; b = 32'hFFFFFFFD; in_valid = 1'b1;
    md_model(6'h1A, 32'd1000, 32'hFFFFFFFD);
    tick();
    check("ovl_busy", md_busy, 1'b1);
    alu_op = 3'b100; a = r1; b = r2;
    tick();
    check("ovl_and", {out_valid, result}, {1'b1, r1 & r2});
    alu_op = 3'b010; func = 6'h26;
    tick();
    check("ovl_xor", {out_valid, result}, {1'b1, r1 ^ r2});
    func = 6'h12;
    for (int n = 3; n <= 40; n++) begin
      #1;
      check($sformatf("ovl_c%0d_busy_ready", n), {md_busy, in_ready}, {n <= W + 1, n > W + 1});
      if (n == W + 2) begin
        check("ovl_done", md_done, 1'b1);
        tick();
        check("ovl_mflo", {out_valid, result}, {1'b1, ref_lo});
        break;
      end
      tick();
      check($sformatf("ovl_c%0d_stalled", n), out_valid, 1'b0);
    end
    in_valid = 1'b0;

    // mthi/mtlo write at accept, no out_valid; mfhi next cycle sees new value.
    issue(3'b010, 6'h00, 6'h11, 32'hA5A50001, 32'h0, 5'd0);
    check("mthi_no_valid", out_valid, 1'b0);
    issue(3'b010, 6'h00, 6'h13, 32'h5A5A0002, 32'h0, 5'd0);
    ref_hi = 32'hA5A50001; ref_lo = 32'h5A5A0002;
    read_hilo("mt");

    // Flush in cycle 10 of a mult aborts it without touching HI/LO.
    issue(3'b010, 6'h00, 6'h18, $urandom, $urandom, 5'd0);
    for (int k = 0; k < 9; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy_low", md_busy, 1'b0);
    done_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (md_done !== 1'b0) done_seen = 1'b1;
      tick();
    end
    check("flush_no_done", done_seen, 1'b0);
    read_hilo("flush");

    issue(3'b010, 6'h00, 6'h20, 32'd3, 32'd4, 5'd0);
    check("pre_flush_add", {out_valid, result}, {1'b1, 32'd7});
    flush = 1'b1;
    issue(3'b010, 6'h00, 6'h20, 32'd5, 32'd6, 5'd0);
    flush = 1'b0;
    check("flush_add_dropped", out_valid, 1'b0);

    // Reset mid-operation clears HI/LO and idles the engine.
    issue(3'b010, 6'h00, 6'h19, $urandom, $urandom, 5'd0);
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_md", {md_busy, md_done, out_valid}, 3'b000);
    ref_hi = '0; ref_lo = '0;
    read_hilo("rst_mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised, registered execute stage for the pipelined CPU. It merges the ALU-operation decode (alu_op/op/func) with the datapath. Simple operations complete in one cycle. MULT/MULTU/DIV/DIVU run on an iterative multiply/divide engine with private HI/LO registers, and the unit stalls issue only when an instruction depends on that engine.

## Interface
- WIDTH, 32, datapath width; power of two, 8..64. LUI shift is WIDTH/2. SH = log2(WIDTH).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill: drops this cycle's input, clears out_valid next cycle, aborts a running MD op.
- in_valid  in  1  instruction presented this cycle.
- in_ready  out  1  combinational; the input is accepted on an edge where in_valid & in_ready & ~flush.
- alu_op  in  3  000 add, 001 sub, 100 and, 101 or, 01x R-type (decode func), 11x I-type (decode op); other codes are illegal.
- op  in  6  opcode for I-type decode.
- func  in  6  function field for R-type decode.
- a  in  WIDTH  rs operand.
- b  in  WIDTH  rt operand, or the immediate already extended upstream.
- shamt  in  5  shift amount for sll/srl/sra; bits above SH-1 are ignored.
- out_valid  out  1  registered; result is valid (one-cycle pulse per accepted non-MD op).
- result  out  WIDTH  registered ALU result.
- ovf  out  1  signed overflow; qualified by out_valid.
- illegal  out  1  undecodable op; qualified by out_valid; result=0.
- md_busy  out  1  multiply/divide engine active.
- md_done  out  1  one-cycle pulse in the cycle after HI/LO are written.

## Operation
- R-type func codes:
  - 100000 add, 100001 addu, 100010 sub, 100011 subu.
  - 100100 and, 100101 or, 100110 xor, 100111 nor.
  - 101010 slt, 101011 sltu.
  - 000000 sll, 000010 srl, 000011 sra: shift b by shamt.
  - 000100 sllv, 000110 srlv, 000111 srav: shift b by a[SH-1:0].
  - 011000 mult, 011001 multu, 011010 div, 011011 divu.
  - 010000 mfhi, 010010 mflo, 010001 mthi, 010011 mtlo (write source is a).
- I-type op codes: 001000 addi, 001001 addiu, 001100 andi, 001101 ori, 001110 xori, 001111 lui (b<<WIDTH/2), 001010 slti, 001011 sltiu.
- slt/slti: signed compare. sltu/sltiu: unsigned compare. Result is 1 or 0.
- ovf is set only for add, sub, addi, and only on two's-complement overflow. The wrapped result is still output.
- mthi/mtlo update HI/LO at the accept edge, with out_valid=0. mult/div produce no out_valid.
- MD FSM states:
  - IDLE -> MUL or DIV on accept; operands are latched and made absolute for signed ops.
  - MUL/DIV run one bit per cycle for WIDTH cycles (shift-add / restoring), then go to FIX.
  - FIX applies the sign correction, writes HI/LO, then returns to IDLE.
- mult/multu: {HI,LO} = 2·WIDTH-bit product.
- div/divu: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- Divide by zero: LO = all ones, HI = a. No exception is raised.
- in_ready=0 while md_busy for mult/div/mfhi/mflo/mthi/mtlo. All other ops keep in_ready=1, so independent ALU ops flow during an MD op.
- Illegal ops: out_valid=1, illegal=1, result=0, with no HI/LO effect.

## Timing
- Reset: out_valid, result, ovf, illegal, md_busy, md_done, HI, LO all 0; FSM to IDLE; in_ready=1.
- Simple ops: accepted at edge E, and result/out_valid/ovf/illegal are visible in the cycle after E. Latency is 1, with back-to-back throughput of 1 per cycle.
- MD op accepted at edge E0:
  - md_busy is high in cycles 1..WIDTH+1 after E0.
  - HI/LO are written at edge E0+WIDTH+1.
  - md_done is high in cycle WIDTH+2.
  - mfhi/mflo is accepted no earlier than edge E0+WIDTH+2 and returns the new value.
- mfhi/mflo read HI/LO at the accept edge (the value as of before that edge).
- flush at any cycle: out_valid=0 next cycle. A running MD op returns to IDLE, md_busy falls next cycle, HI/LO are unchanged, and md_done does not pulse.
- flush and in_valid in the same cycle: the input is discarded; flush wins.
- rst mid-MD: same as reset; HI/LO are cleared.
- mthi accepted while idle, followed by mfhi next cycle: mfhi returns the new HI.

## Test plan
- Reset, then add a=0x7FFFFFFF b=1 -> next cycle out_valid=1, result=0x80000000, ovf=1. The same with addu -> ovf=0.
- sra b=0x80000000 shamt=4 -> 0xF8000000. srav a=0x24 (uses 4) b=0xF0 -> 0x0F. lui b=0x1234 -> 0x12340000. sltiu a=1 b=0xFFFFFFFF -> 1. slti the same -> 0.
- mult a=0xFFFFFFFF b=2 -> md_busy for 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu the same -> HI=1, LO=0xFFFFFFFE. Confirm via mfhi/mflo.
- div a=-7 b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 100/7 -> LO=14, HI=2. divu 5/0 -> LO=0xFFFFFFFF, HI=5.
- During a running div, issue an and, an xor, then an mflo:
  - The ALU ops complete at 1/cycle.
  - mflo sees in_ready=0 until md_busy falls, then returns the quotient.
- Assert flush at cycle 10 of a mult -> md_busy low next cycle, HI/LO keep their prior values, no md_done. Also: flush with a simultaneous add -> no out_valid.
